fadsu_acc: RTL and testbench
============================

FADSU_ACC -- requirements
Module: fadsu_acc

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width in bits (legal 2..32, even values only).
REQ-002 SHALL provide parameter SAT_EN, default 1, enabling saturation logic (0: SAT input ignored, treated as 0).
REQ-003 SHALL have ports, listed as name  direction  width  meaning:
- CK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high.
- CE  input  1  clock enable; 0 = all registers hold.
- VI  input  1  operand valid.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- BCI  input  1  carry-in on add, active-low borrow-in on subtract.
- CON  input  1  mode: 1 = add, 0 = subtract.
- ACC  input  1  1 = use internal accumulator in place of A.
- CLR  input  1  synchronous accumulator clear.
- SAT  input  1  1 = signed saturation on overflow.
- S  output  WIDTH  registered result.
- BCO  output  1  registered carry-out, active-low borrow-out.
- OVF  output  1  registered signed overflow of the current result.
- OVFS  output  1  sticky overflow.
- VO  output  1  result valid.

Function
REQ-004 SHALL compute Beff = B when CON=1 and Beff = ~B when CON=0, then SUM = Aop + Beff + BCI at WIDTH+1 bits.
REQ-005 SHALL take Aop = A when ACC=0, accumulator register when ACC=1, zero when ACC=1 and CLR=1.
REQ-006 SHALL set raw BCO = SUM[WIDTH]; this raw value is unaffected by saturation.
REQ-007 SHALL flag overflow when Aop[MSB] == Beff[MSB] and SUM[MSB] != Aop[MSB].
REQ-008 SHALL clamp the result on overflow with SAT=1 (and SAT_EN=1) to 0x7F..F when Aop[MSB]=0 and to 0x80..0 when Aop[MSB]=1; otherwise the result is SUM[WIDTH-1:0].
REQ-009 SHALL register S, BCO, OVF on a rising edge when CE=1 and VI=1, so that latency is exactly 1 cycle.
REQ-010 SHALL set VO to (VI & CE-qualified) each CE=1 edge; S, BCO, OVF SHALL hold when VI=0.
REQ-011 SHALL load the accumulator register with the (possibly saturated) result on every accepted op (CE=1, VI=1), regardless of ACC.
REQ-012 SHALL clear the accumulator to 0 on a CE=1 edge with CLR=1 and VI=0.
REQ-013 SHALL, when CLR=1 and VI=1 occur together, use zero as Aop if ACC=1, with the result loaded into the accumulator (clear then operate).
REQ-014 SHALL set OVFS on any accepted op with overflow; it SHALL be cleared only by RST or CLR (CLR clears OVFS unless the same-cycle op overflows, in which case it is set).
REQ-015 SHALL freeze all registers, including VO, OVFS, and the accumulator, when CE=0; VI, CLR, and operands are ignored.
REQ-016 SHALL keep all arithmetic modulo 2^WIDTH when SAT=0; no wider internal state SHALL be exposed.

Reset
REQ-017 SHALL force S=0, BCO=0, OVF=0, OVFS=0, VO=0, and accumulator=0 on a rising edge with RST=1, independent of CE, VI, and CLR.
REQ-018 SHALL discard an op presented in the same cycle as RST=1; the first valid result after reset SHALL appear 1 cycle after the first accepted VI.
REQ-019 SHALL have RST take priority over CLR and CE.

Verification (WIDTH=8, SAT_EN=1)
REQ-020 SHALL cover: A=0x7F, B=0x01, CON=1, BCI=0, SAT=0, VI=1 -> next cycle S=0x80, OVF=1, BCO=0, VO=1, OVFS=1.
REQ-021 SHALL cover: the same stimulus with SAT=1 -> S=0x7F, OVF=1, accumulator=0x7F; and A=0x80, B=0x01, CON=0, BCI=1, SAT=1 -> S=0x80, OVF=1.
REQ-022 SHALL cover: A=0x05, B=0x07, CON=0, BCI=1 -> S=0xFE, BCO=0 (borrow), OVF=0; and A=0x07, B=0x05 -> S=0x02, BCO=1.
REQ-023 SHALL cover: CLR=1, VI=1, ACC=1, B=0x10, CON=1, BCI=0, then two more ops with ACC=1, CLR=0 -> S=0x10, 0x20, 0x30 on consecutive cycles, with VO=1 each cycle.
REQ-024 SHALL cover: CE=0 for 3 cycles with VI=1 toggling operands -> S, VO, OVFS, and accumulator unchanged; CE=1 resumes with 1-cycle latency.
REQ-025 SHALL cover: RST=1 mid-accumulation, with accumulator=0x30 and OVFS=1 -> next edge all outputs 0; the following op with ACC=1, B=0x01 -> S=0x01.

Source files
------------

// File: rtl/fadsu_acc.sv
// Add/subtract unit with accumulator, signed saturation and sticky overflow.
// One-cycle registered result; CE freezes all state, RST wins over everything.
module fadsu_acc #(
  parameter int WIDTH  = 8,
  parameter int SAT_EN = 1
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             CE,
  input  logic             VI,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BCI,
  input  logic             CON,
  input  logic             ACC,
  input  logic             CLR,
  input  logic             SAT,
  output logic [WIDTH-1:0] S,
  output logic             BCO,
  output logic             OVF,
  output logic             OVFS,
  output logic             VO
);

  localparam logic [WIDTH-1:0] MAXP =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINN =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             bco_q, bco_d;
  logic             ovf_q, ovf_d;
  logic             ovfs_q, ovfs_d;
  logic             vo_q, vo_d;

  logic [WIDTH-1:0] aop;
  logic [WIDTH-1:0] beff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             ovf;
  logic             sat_on;
  logic             take;

  always_comb begin
    aop    = ACC ? (CLR ? '0 : acc_q) : A;
    beff   = CON ? B : ~B;
    sum    = {1'b0, aop} + {1'b0, beff}
           + {{WIDTH{1'b0}}, BCI};
    ovf    = (aop[WIDTH-1] == beff[WIDTH-1])
           && (sum[WIDTH-1] != aop[WIDTH-1]);
    sat_on = (SAT_EN != 0) && SAT;
    res    = sum[WIDTH-1:0];
    if (ovf && sat_on)
      res = aop[WIDTH-1] ? MINN : MAXP;
  end

  assign take = CE && VI;

  always_comb begin
    s_d    = s_q;
    acc_d  = acc_q;
    bco_d  = bco_q;
    ovf_d  = ovf_q;
    ovfs_d = ovfs_q;
    vo_d   = vo_q;
    if (CE) begin
      vo_d = VI;
      // CLR alone clears; a same-cycle op reloads acc and may re-set OVFS
      if (CLR) begin
        acc_d  = '0;
        ovfs_d = 1'b0;
      end
      if (take) begin
        s_d   = res;
        acc_d = res;
        bco_d = sum[WIDTH];
        ovf_d = ovf;
        if (ovf)
          ovfs_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      s_q    <= '0;
      acc_q  <= '0;
      bco_q  <= 1'b0;
      ovf_q  <= 1'b0;
      ovfs_q <= 1'b0;
      vo_q   <= 1'b0;
    end else begin
      s_q    <= s_d;
      acc_q  <= acc_d;
      bco_q  <= bco_d;
      ovf_q  <= ovf_d;
      ovfs_q <= ovfs_d;
      vo_q   <= vo_d;
    end
  end

  assign S    = s_q;
  assign BCO  = bco_q;
  assign OVF  = ovf_q;
  assign OVFS = ovfs_q;
  assign VO   = vo_q;

endmodule

// File: tb/tb_fadsu_acc.sv
// Bench for fadsu_acc: directed literal cases plus random ops
// checked every cycle against an integer-arithmetic reference model.
module tb_fadsu_acc;

  logic       CK = 1'b0;
  logic       RST, CE, VI, BCI, CON, ACC, CLR, SAT;
  logic [7:0] A, B;
  logic [7:0] S;
  logic       BCO, OVF, OVFS, VO;

  int n_cmp = 0;
  int n_err = 0;

  fadsu_acc #(.WIDTH(8), .SAT_EN(1)) dut (
    .CK(CK), .RST(RST), .CE(CE), .VI(VI),
    .A(A), .B(B), .BCI(BCI), .CON(CON),
    .ACC(ACC), .CLR(CLR), .SAT(SAT),
    .S(S), .BCO(BCO), .OVF(OVF),
    .OVFS(OVFS), .VO(VO)
  );

  always #5 CK = ~CK;

  // reference model: plain integers, signed range check for overflow
  int  m_s, m_acc;
  bit  m_bco, m_ovf, m_ovfs, m_vo;
  bit  chk_en = 1'b0;
  int  r_aop, r_beff, r_sum, r_sa, r_sb;
  int  r_ss, r_res;
  bit  r_ov;

  always @(posedge CK) begin
    if (RST) begin
      m_s <= 0; m_acc <= 0; m_bco <= 0;
      m_ovf <= 0; m_ovfs <= 0; m_vo <= 0;
      chk_en <= 1'b1;
    end else if (CE) begin
      m_vo <= VI;
      if (VI) begin
        r_aop  = ACC ? (CLR ? 0 : m_acc) : int'(A);
        r_beff = CON ? int'(B) : 255 - int'(B);
        r_sum  = r_aop + r_beff + int'(BCI);
        r_sa   = r_aop  > 127 ? r_aop  - 256 : r_aop;
        r_sb   = r_beff > 127 ? r_beff - 256 : r_beff;
        r_ss   = r_sa + r_sb + int'(BCI);
        r_ov   = (r_ss > 127) || (r_ss < -128);
        r_res  = r_sum % 256;
        if (r_ov && SAT)
          r_res = r_ss > 127 ? 127 : 128;
        m_s    <= r_res;
        m_acc  <= r_res;
        m_bco  <= r_sum > 255;
        m_ovf  <= r_ov;
        m_ovfs <= r_ov || (m_ovfs && !CLR);
      end else if (CLR) begin
        m_acc  <= 0;
        m_ovfs <= 0;
      end
    end
  end

  always @(negedge CK) begin
    if (chk_en) begin
      n_cmp += 5;
      if (S != m_s[7:0] || BCO != m_bco ||
          OVF != m_ovf || OVFS != m_ovfs ||
          VO != m_vo) begin
        n_err++;
        $display("FAIL model t=%0t got S=%h BCO=%b OVF=%b OVFS=%b VO=%b exp S=%h BCO=%b OVF=%b OVFS=%b VO=%b",
          $time, S, BCO, OVF, OVFS, VO,
          m_s[7:0], m_bco, m_ovf, m_ovfs, m_vo);
      end
    end
  end

  task automatic chk(input string n,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", n, got, exp);
    end
  endtask

  task automatic op(input bit ce, vi, acc, clr,
                    input bit sat, con, bci,
                    input logic [7:0] a, b);
    RST = 0; CE = ce; VI = vi; ACC = acc;
    CLR = clr; SAT = sat; CON = con; BCI = bci;
    A = a; B = b;
    @(posedge CK); #1;
  endtask

  task automatic rst(input bit ce, clr, vi);
    RST = 1; CE = ce; CLR = clr; VI = vi;
    ACC = 0; SAT = 0; CON = 1; BCI = 0;
    A = 8'h55; B = 8'h11;
    @(posedge CK); #1;
  endtask

  initial begin
    rst(1, 0, 0);
    rst(0, 0, 1);
    chk("rst_S", S, 8'h00);
    chk("rst_VO", {7'b0, VO}, 8'h00);
    chk("rst_OVFS", {7'b0, OVFS}, 8'h00);
    chk("rst_BCO", {7'b0, BCO}, 8'h00);

    //   ce vi ac cl st cn bci a      b
    op(1, 1, 0, 0, 0, 1, 0, 8'h7F, 8'h01);
    chk("wrap_S", S, 8'h80);
    chk("wrap_OVF", {7'b0, OVF}, 8'h01);
    chk("wrap_BCO", {7'b0, BCO}, 8'h00);
    chk("wrap_VO", {7'b0, VO}, 8'h01);
    chk("wrap_OVFS", {7'b0, OVFS}, 8'h01);

    op(1, 1, 0, 0, 1, 1, 0, 8'h7F, 8'h01);
    chk("satp_S", S, 8'h7F);
    chk("satp_OVF", {7'b0, OVF}, 8'h01);
    op(1, 1, 1, 0, 0, 1, 0, 8'h00, 8'h00);
    chk("satp_acc", S, 8'h7F);
    chk("acc_OVF", {7'b0, OVF}, 8'h00);

    op(1, 1, 0, 0, 1, 0, 1, 8'h80, 8'h01);
    chk("satn_S", S, 8'h80);
    chk("satn_OVF", {7'b0, OVF}, 8'h01);

    op(1, 1, 0, 0, 0, 0, 1, 8'h05, 8'h07);
    chk("bor_S", S, 8'hFE);
    chk("bor_BCO", {7'b0, BCO}, 8'h00);
    chk("bor_OVF", {7'b0, OVF}, 8'h00);
    op(1, 1, 0, 0, 0, 0, 1, 8'h07, 8'h05);
    chk("nbor_S", S, 8'h02);
    chk("nbor_BCO", {7'b0, BCO}, 8'h01);

    op(1, 1, 1, 1, 0, 1, 0, 8'hAA, 8'h10);
    chk("acc1_S", S, 8'h10);
    chk("clr_OVFS", {7'b0, OVFS}, 8'h00);
    op(1, 1, 1, 0, 0, 1, 0, 8'hAA, 8'h10);
    chk("acc2_S", S, 8'h20);
    chk("acc2_VO", {7'b0, VO}, 8'h01);
    op(1, 1, 1, 0, 0, 1, 0, 8'hAA, 8'h10);
    chk("acc3_S", S, 8'h30);

    for (int i = 0; i < 3; i++) begin
      op(0, 1, i[0], 1, 1, 1, 1,
         8'($urandom), 8'($urandom));
      chk("frz_S", S, 8'h30);
      chk("frz_VO", {7'b0, VO}, 8'h01);
      chk("frz_OVFS", {7'b0, OVFS}, 8'h00);
    end
    op(1, 1, 1, 0, 0, 1, 0, 8'h00, 8'h00);
    chk("resume_S", S, 8'h30);

    op(1, 1, 0, 0, 0, 1, 0, 8'h98, 8'h98);
    chk("neg_ovf_S", S, 8'h30);
    chk("neg_OVFS", {7'b0, OVFS}, 8'h01);
    op(1, 0, 0, 0, 0, 1, 0, 8'h01, 8'h01);
    chk("idle_VO", {7'b0, VO}, 8'h00);
    chk("idle_S", S, 8'h30);

    rst(0, 1, 1);
    chk("mrst_S", S, 8'h00);
    chk("mrst_OVFS", {7'b0, OVFS}, 8'h00);
    chk("mrst_OVF", {7'b0, OVF}, 8'h00);
    op(1, 1, 1, 0, 0, 1, 0, 8'h44, 8'h01);
    chk("post_rst_S", S, 8'h01);

    op(1, 0, 0, 1, 0, 1, 0, 8'h00, 8'h00);
    op(1, 1, 1, 0, 0, 1, 0, 8'h00, 8'h05);
    chk("clr_idle_S", S, 8'h05);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(63) == 0)
        rst($urandom_range(1), $urandom_range(1),
            $urandom_range(1));
      else
        op($urandom_range(9) != 0,
           $urandom_range(9) < 7,
           $urandom_range(1),
           $urandom_range(9) == 0,
           $urandom_range(1),
           $urandom_range(1),
           $urandom_range(1),
           8'($urandom), 8'($urandom));
    end

    @(negedge CK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
